chacha_poly_block_packer: RTL
=============================

// Module: chacha_poly_block_packer
// PURPOSE
//  Upstream feeder for the ChaCha20-Poly1305 adapter. It packs a 32-bit AAD/payload word stream into
//  128-bit little-endian Poly1305 blocks with byte-keep masks, zero-pads each segment's final partial
//  block, counts segment lengths and emits the final LEN block {pld_len_bytes[63:0], aad_len_bytes[63:0]}.
//  Its outputs connect directly to the adapter's aad_*/pld_*/len_* ready/valid channels.
// PARAMETERS
//  LEN_W  64  width of the AAD and payload byte counters; counters wrap modulo 2^LEN_W
// PORTS
//  clk        in   1    clock; single clock domain
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    pulse; clears counters and (re)starts a message in any state
//  s_valid    in   1    input word valid
//  s_data     in   32   input bytes; byte i = s_data[8i+7:8i], low-aligned
//  s_bytes    in   3    valid bytes in word, 0..4; 0 is legal only with s_last
//  s_last     in   1    last word of the current segment
//  s_is_aad   in   1    1 = AAD segment word, 0 = payload word
//  s_ready    out  1    word accepted when s_valid && s_ready
//  aad_valid/aad_data[127:0]/aad_keep[15:0] out, aad_ready in   AAD block channel
//  pld_valid/pld_data[127:0]/pld_keep[15:0] out, pld_ready in   payload block channel
//  len_valid/len_block[127:0] out, len_ready in                  length block channel
//  err        out  1    one-cycle pulse on a protocol violation
//  done       out  1    one-cycle pulse when the LEN block handshakes
// BEHAVIOUR
//  Reset: state IDLE; s_ready=0; every valid, err and done = 0; data, keep, block and counters = 0.
//  States: IDLE, AAD_FILL, AAD_EMIT, PLD_FILL, PLD_EMIT, LEN_EMIT.
//  IDLE: s_ready=0. On start, go to AAD_FILL.
//  *_FILL: s_ready=1. Each accepted word writes bytes [4w+3:4w] of the assembly register, sets the
//   matching keep bits for the s_bytes low lanes and adds s_bytes to the segment counter.
//   Unused lanes are forced to 0 (zero padding).
//  Emit trigger: the 4th word of a block, or any word with s_last, loads the output register.
//   valid rises the next cycle and the state moves to *_EMIT. Latency is 1 cycle from the final accepted word.
//  *_EMIT: s_ready=0. data and keep stay stable while valid && !ready. On the ready handshake:
//   - block was not last: return to *_FILL;
//   - AAD last: go to PLD_FILL;
//   - payload last: go to LEN_EMIT.
//  Empty segment: a word with s_bytes=0 and s_last emits NO block.
//   Empty AAD goes AAD_FILL -> PLD_FILL. Empty payload goes PLD_FILL -> LEN_EMIT.
//  Empty-block rule: a last word with s_bytes=0 arriving on a 16-byte boundary emits no extra block.
//   The previous full block was already emitted as not-last; the state transitions directly.
//  LEN_EMIT: len_block[63:0]=aad_len and len_block[127:64]=pld_len (bytes, little-endian).
//   len_valid is held until len_ready. On the handshake, pulse done and return to IDLE.
//  Protocol errors (err pulse; word consumed and dropped; counters unchanged):
//   - s_is_aad=1 in PLD_FILL;
//   - s_bytes in 1..3 without s_last;
//   - s_bytes>4;
//   - s_bytes=0 without s_last.
//  A payload word (s_is_aad=0) arriving in AAD_FILL implicitly closes the AAD segment:
//   any partial AAD block is emitted as last, then that word is processed in PLD_FILL.
//   s_ready=0 until the AAD emit completes; the word is not accepted early.
//  start in any non-IDLE state aborts the message:
//   - next cycle: all valids=0, counters=0, assembly cleared, state AAD_FILL;
//   - any in-flight block is discarded, done is not pulsed.
//  Async reset mid-operation returns immediately to reset values.
//  Throughput: 1 word/cycle while filling, plus >=1 emit cycle per block.
// STRUCTURE
//  Shared package: state encoding, BLK_BYTES=16, WORD_BYTES=4, keep-mask helper function.
//  One natural sub-module: chacha_poly_word_packer. It holds the 32->128 lane write, keep
//   generation and word index. The FSM, counters and output registers stay in the top.
// TESTING
//  1. AAD 12B (3 full words, last) + payload 32B -> aad_keep=16'h0FFF, aad_data[127:96]=0;
//     two pld blocks with keep=16'hFFFF; len_block={64'd32,64'd12}; done pulses once.
//  2. Empty AAD (bytes=0,last) + payload 5B (4B word + 1B last) -> no aad_valid;
//     pld_keep=16'h001F, pld_data[127:40]=0; len_block={64'd5,64'd0}.
//  3. pld_ready held low 5 cycles during PLD_EMIT -> pld_data/pld_keep stable, s_ready=0;
//     the block is accepted exactly once.
//  4. AAD word sent after payload began -> err=1 for 1 cycle; the LEN block still reports
//     only the bytes of the legal words.
//  5. start asserted mid-payload with pld_valid=1 -> pld_valid=0 next cycle; a new 16B AAD
//     yields len_block={64'd0+pld,64'd16} for the new message only.
//  6. rst_n dropped during LEN_EMIT -> len_valid=0 and s_ready=0 asynchronously;
//     no done pulse after release.

Source files
------------

// File: rtl/chacha_poly_block_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chacha_poly_block_packer_pkg
// Brief    : Shared constants, state encoding and keep-mask helper for the
//            ChaCha20-Poly1305 block packer.
// Revision : 1.0
// ============================================================================
package chacha_poly_block_packer_pkg;

    localparam int BLK_BYTES     = 16;
    localparam int WORD_BYTES    = 4;
    localparam int WORDS_PER_BLK = BLK_BYTES / WORD_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_AAD_FILL = 3'd1,
        ST_AAD_EMIT = 3'd2,
        ST_PLD_FILL = 3'd3,
        ST_PLD_EMIT = 3'd4,
        ST_LEN_EMIT = 3'd5
    } state_t;

    // Low-aligned lane mask: one bit per valid byte of a word.
    function automatic logic [WORD_BYTES-1:0] keep_mask(input logic [2:0] nbytes);
        logic [WORD_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (int'(nbytes) > i) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chacha_poly_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : chacha_poly_word_packer
// Brief    : 32->128 bit lane assembler with zero-padded byte-keep tracking.
// Revision : 1.0
// ============================================================================
module chacha_poly_word_packer
    import chacha_poly_block_packer_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr,
    input  logic         i_clr,
    input  logic [31:0]  i_data,
    input  logic [2:0]   i_bytes,
    output logic [1:0]   o_word_idx,
    output logic [127:0] o_asm_data,
    output logic [15:0]  o_asm_keep,
    output logic [127:0] o_merged_data,
    output logic [15:0]  o_merged_keep
);

    logic [127:0]          r_data;
    logic [15:0]           r_keep;
    logic [1:0]            r_idx;
    logic [WORD_BYTES-1:0] w_lane_keep;
    logic [31:0]           w_lane_data;

    assign w_lane_keep = keep_mask(i_bytes);

    // Bytes beyond the valid count are forced to zero so partial blocks pad cleanly.
    generate
        for (genvar b = 0; b < WORD_BYTES; b++) begin : g_byte
            assign w_lane_data[8*b +: 8] = w_lane_keep[b] ? i_data[8*b +: 8] : 8'h00;
        end
    endgenerate

    generate
        for (genvar w = 0; w < WORDS_PER_BLK; w++) begin : g_slot
            assign o_merged_data[32*w +: 32] = (r_idx == 2'(w)) ? w_lane_data : r_data[32*w +: 32];
            assign o_merged_keep[4*w +: 4]   = (r_idx == 2'(w)) ? w_lane_keep : r_keep[4*w +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_keep <= '0;
            r_idx  <= '0;
        end else if (i_clr) begin
            r_data <= '0;
            r_keep <= '0;
            r_idx  <= '0;
        end else if (i_wr) begin
            r_data <= o_merged_data;
            r_keep <= o_merged_keep;
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign o_word_idx = r_idx;
    assign o_asm_data = r_data;
    assign o_asm_keep = r_keep;

endmodule
`default_nettype wire

// File: rtl/chacha_poly_block_packer.sv
`default_nettype none
// ============================================================================
// Module   : chacha_poly_block_packer
// Brief    : Packs AAD/payload words into 128-bit Poly1305 blocks and emits
//            the final {pld_len, aad_len} LEN block.
// Revision : 1.0
// ============================================================================
module chacha_poly_block_packer
    import chacha_poly_block_packer_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         s_valid,
    input  logic [31:0]  s_data,
    input  logic [2:0]   s_bytes,
    input  logic         s_last,
    input  logic         s_is_aad,
    output logic         s_ready,
    output logic         aad_valid,
    output logic [127:0] aad_data,
    output logic [15:0]  aad_keep,
    input  logic         aad_ready,
    output logic         pld_valid,
    output logic [127:0] pld_data,
    output logic [15:0]  pld_keep,
    input  logic         pld_ready,
    output logic         len_valid,
    output logic [127:0] len_block,
    input  logic         len_ready,
    output logic         err,
    output logic         done
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [127:0]       r_blk_data;
    logic [15:0]        r_blk_keep;
    logic               r_last;
    logic [LEN_W-1:0]   r_aad_len;
    logic [LEN_W-1:0]   r_pld_len;
    logic               r_err;
    logic               r_done;

    logic [1:0]         w_word_idx;
    logic [127:0]       w_asm_data;
    logic [15:0]        w_asm_keep;
    logic [127:0]       w_merged_data;
    logic [15:0]        w_merged_keep;

    logic               w_in_aad;
    logic               w_word_bad;
    logic               w_trigger;
    logic               w_s_ready;
    logic               w_accept;
    logic               w_load;
    logic               w_load_word;
    logic               w_load_last;
    logic               w_pk_wr;
    logic               w_pk_clr;
    logic               w_clear_cnt;
    logic               w_err;
    logic               w_done;

    chacha_poly_word_packer u_word_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr          (w_pk_wr),
        .i_clr         (w_pk_clr),
        .i_data        (s_data),
        .i_bytes       (s_bytes),
        .o_word_idx    (w_word_idx),
        .o_asm_data    (w_asm_data),
        .o_asm_keep    (w_asm_keep),
        .o_merged_data (w_merged_data),
        .o_merged_keep (w_merged_keep)
    );

    assign w_in_aad   = (r_state == ST_AAD_FILL);
    // Only full words may precede the last word of a segment.
    assign w_word_bad = (s_bytes > 3'd4) || (!s_last && (s_bytes != 3'd4));
    assign w_trigger  = (w_word_idx == 2'd3) || s_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_load_word = 1'b0;
        w_load_last = 1'b0;
        w_pk_wr     = 1'b0;
        w_pk_clr    = 1'b0;
        w_clear_cnt = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        if (start) begin
            w_state_nxt = ST_AAD_FILL;
            w_pk_clr    = 1'b1;
            w_clear_cnt = 1'b1;
        end else begin
            case (r_state)
                ST_AAD_FILL, ST_PLD_FILL: begin
                    if (w_in_aad && s_valid && !s_is_aad) begin
                        // Payload word closes the AAD segment; it is held off until PLD_FILL.
                        w_pk_clr = 1'b1;
                        if (|w_asm_keep) begin
                            w_load      = 1'b1;
                            w_load_last = 1'b1;
                            w_state_nxt = ST_AAD_EMIT;
                        end else begin
                            w_state_nxt = ST_PLD_FILL;
                        end
                    end else begin
                        w_s_ready = 1'b1;
                        if (s_valid) begin
                            if (w_word_bad || (!w_in_aad && s_is_aad)) begin
                                w_err = 1'b1;
                            end else begin
                                w_accept = 1'b1;
                                if (w_trigger) begin
                                    w_pk_clr = 1'b1;
                                    if (|w_merged_keep) begin
                                        w_load      = 1'b1;
                                        w_load_word = 1'b1;
                                        w_load_last = s_last;
                                        w_state_nxt = w_in_aad ? ST_AAD_EMIT : ST_PLD_EMIT;
                                    end else begin
                                        w_state_nxt = w_in_aad ? ST_PLD_FILL : ST_LEN_EMIT;
                                    end
                                end else begin
                                    w_pk_wr = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_AAD_EMIT: begin
                    if (aad_ready) begin
                        w_state_nxt = r_last ? ST_PLD_FILL : ST_AAD_FILL;
                    end
                end
                ST_PLD_EMIT: begin
                    if (pld_ready) begin
                        w_state_nxt = r_last ? ST_LEN_EMIT : ST_PLD_FILL;
                    end
                end
                ST_LEN_EMIT: begin
                    if (len_ready) begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_data <= '0;
            r_blk_keep <= '0;
            r_last     <= 1'b0;
            r_aad_len  <= '0;
            r_pld_len  <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_err  <= w_err;
            r_done <= w_done;
            if (w_load) begin
                r_blk_data <= w_load_word ? w_merged_data : w_asm_data;
                r_blk_keep <= w_load_word ? w_merged_keep : w_asm_keep;
                r_last     <= w_load_last;
            end
            if (w_clear_cnt) begin
                r_aad_len <= '0;
                r_pld_len <= '0;
            end else if (w_accept) begin
                if (w_in_aad) begin
                    r_aad_len <= r_aad_len + LEN_W'(s_bytes);
                end else begin
                    r_pld_len <= r_pld_len + LEN_W'(s_bytes);
                end
            end
        end
    end

    assign s_ready   = w_s_ready;
    assign aad_valid = (r_state == ST_AAD_EMIT);
    assign aad_data  = r_blk_data;
    assign aad_keep  = r_blk_keep;
    assign pld_valid = (r_state == ST_PLD_EMIT);
    assign pld_data  = r_blk_data;
    assign pld_keep  = r_blk_keep;
    assign len_valid = (r_state == ST_LEN_EMIT);
    assign len_block = {64'(r_pld_len), 64'(r_aad_len)};
    assign err       = r_err;
    assign done      = r_done;

endmodule
`default_nettype wire
